// File: rtl/rtc_lector_bus_if.sv
// rtc_lector_bus_if: multiplexed address/data bus of the RTC chip.
// The master (rtc_lector_bus) drives the strobes and the AD output;
// the slave (the RTC chip or its model) returns data on ad_in.
interface rtc_lector_bus_if;
    logic [7:0] ad_in;   // RTC -> master, sampled during read strobes
    logic [7:0] ad_out;  // master -> RTC, valid while ad_oe = 1
    logic       ad_oe;   // 1 = master drives the AD bus
    logic       cs_n;    // chip select, active low
    logic       rd_n;    // read strobe, active low
    logic       wr_n;    // write strobe, active low
    logic       a_d;     // 0 = address cycle, 1 = data cycle

    modport master (
        input  ad_in,
        output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
    );

    modport slave (
        output ad_in,
        input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
    );
endinterface

// File: rtl/rtc_lector_bus.sv
// rtc_lector_bus: bus master that sweeps the nine RTC time/date/chronometer
// registers, gathers them in shadow registers and publishes all nine bytes
// at once so the display never sees a half-updated time.
// Optional macro RTC_TRANSFERENCIA_EN: prefix every sweep with a write of
// command 0xF0 (latch RTC counters) before the first register read.
module rtc_lector_bus #(
    parameter int unsigned T_PULSO  = 4,        // strobe length, 1..15
    parameter int unsigned T_ESPERA = 2,        // idle gap after a strobe, 1..15
    parameter int unsigned PERIODO  = 1000000   // cycles between automatic sweeps
) (
    input  logic             reloj_nexys,
    input  logic             reset_total,       // synchronous, active low
    input  logic             leer_ya,
    input  logic             pausa,
    rtc_lector_bus_if.master bus,
    output logic [7:0]       seg_x,
    output logic [7:0]       min_x,
    output logic [7:0]       hora_x,
    output logic [7:0]       dia_x,
    output logic [7:0]       mes_x,
    output logic [7:0]       year_x,
    output logic [7:0]       seg_crono,
    output logic [7:0]       min_crono,
    output logic [7:0]       hora_crono,
    output logic             ocupado,
    output logic             datos_validos
);

`ifdef RTC_TRANSFERENCIA_EN
    localparam logic CMD_EN = 1'b1;
`else
    localparam logic CMD_EN = 1'b0;
`endif

    localparam logic [7:0]  DIR_TRANSFER = 8'hF0;
    localparam logic [3:0]  ULT_PULSO    = 4'(T_PULSO - 1);
    localparam logic [3:0]  ULT_ESPERA   = 4'(T_ESPERA - 1);
    localparam logic [23:0] ULT_PERIODO  = 24'(PERIODO - 1);
    localparam logic [3:0]  ULT_INDICE   = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ESP1,
        LEER,
        ESP2,
        PUBLICAR
    } estado_t;

    // All bus control lines travel together so every phase sets them in one go.
    typedef struct packed {
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic       a_d;
        logic       ad_oe;
        logic [7:0] ad_out;
    } ctl_t;

    localparam ctl_t CTL_REPOSO = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, a_d: 1'b1,
                                    ad_oe: 1'b0, ad_out: 8'h00};
    // Gap after the address strobe keeps a_d in address position.
    localparam ctl_t CTL_ESP1   = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, a_d: 1'b0,
                                    ad_oe: 1'b0, ad_out: 8'h00};
    // Read strobe: bus released so the RTC can drive it.
    localparam ctl_t CTL_LEER   = '{cs_n: 1'b0, rd_n: 1'b0, wr_n: 1'b1, a_d: 1'b1,
                                    ad_oe: 1'b0, ad_out: 8'h00};

    function automatic ctl_t ctl_dir(input logic [7:0] dir);
        ctl_dir = '{cs_n: 1'b0, rd_n: 1'b1, wr_n: 1'b0, a_d: 1'b0,
                    ad_oe: 1'b1, ad_out: dir};
    endfunction

    // Register address for sweep index 0..8.
    function automatic logic [7:0] dir_reg(input logic [3:0] idx);
        case (idx)
            4'd0:    dir_reg = 8'h21;
            4'd1:    dir_reg = 8'h22;
            4'd2:    dir_reg = 8'h23;
            4'd3:    dir_reg = 8'h24;
            4'd4:    dir_reg = 8'h25;
            4'd5:    dir_reg = 8'h26;
            4'd6:    dir_reg = 8'h41;
            4'd7:    dir_reg = 8'h42;
            4'd8:    dir_reg = 8'h43;
            default: dir_reg = 8'h21;
        endcase
    endfunction

    estado_t     estado_q;
    ctl_t        ctl_q;
    logic [3:0]  cnt_q;
    logic [3:0]  idx_q;
    logic        cmd_q;
    logic        pend_q;
    logic [23:0] per_q;
    logic        ocupado_q;
    logic        dv_q;
    logic [7:0]  shadow_q [0:8];
    logic [7:0]  pub_q    [0:8];

    logic [23:0] per_d;
    logic [3:0]  cnt_d;
    logic [3:0]  idx_d;
    logic        wrap;

    assign wrap  = (per_q == ULT_PERIODO);
    assign per_d = wrap ? 24'd0 : per_q + 24'd1;
    assign cnt_d = cnt_q + 4'd1;
    assign idx_d = idx_q + 4'd1;

    // Sweep sequencer: period counter, request flag, phase timing, shadow capture and publish.
    always_ff @(posedge reloj_nexys) begin
        if (!reset_total) begin
            estado_q  <= IDLE;
            ctl_q     <= CTL_REPOSO;
            cnt_q     <= 4'd0;
            idx_q     <= 4'd0;
            cmd_q     <= 1'b0;
            pend_q    <= 1'b0;
            per_q     <= 24'd0;
            ocupado_q <= 1'b0;
            dv_q      <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                shadow_q[i] <= 8'h00;
                pub_q[i]    <= 8'h00;
            end
        end else begin
            per_q  <= per_d;
            // Requests collapse into one flag; a sweep start clears it below.
            pend_q <= pend_q | leer_ya | wrap;
            dv_q   <= 1'b0;
            case (estado_q)
                IDLE: begin
                    if (pend_q && !pausa) begin
                        pend_q    <= leer_ya | wrap;
                        estado_q  <= ADDR;
                        cnt_q     <= 4'd0;
                        idx_q     <= 4'd0;
                        cmd_q     <= CMD_EN;
                        ocupado_q <= 1'b1;
                        ctl_q     <= ctl_dir(CMD_EN ? DIR_TRANSFER : dir_reg(4'd0));
                    end
                end
                ADDR: begin
                    if (cnt_q == ULT_PULSO) begin
                        cnt_q    <= 4'd0;
                        estado_q <= ESP1;
                        ctl_q    <= CTL_ESP1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ESP1: begin
                    if (cnt_q == ULT_ESPERA) begin
                        cnt_q <= 4'd0;
                        if (cmd_q) begin
                            // Latch command has no data phase; go address the first register.
                            cmd_q    <= 1'b0;
                            estado_q <= ADDR;
                            ctl_q    <= ctl_dir(dir_reg(idx_q));
                        end else begin
                            estado_q <= LEER;
                            ctl_q    <= CTL_LEER;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                LEER: begin
                    if (cnt_q == ULT_PULSO) begin
                        cnt_q            <= 4'd0;
                        shadow_q[idx_q]  <= bus.ad_in;
                        estado_q         <= ESP2;
                        ctl_q            <= CTL_REPOSO;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ESP2: begin
                    if (cnt_q == ULT_ESPERA) begin
                        cnt_q <= 4'd0;
                        if (idx_q == ULT_INDICE) begin
                            estado_q <= PUBLICAR;
                            dv_q     <= 1'b1;
                            for (int i = 0; i < 9; i++) begin
                                pub_q[i] <= shadow_q[i];
                            end
                        end else begin
                            idx_q    <= idx_d;
                            estado_q <= ADDR;
                            ctl_q    <= ctl_dir(dir_reg(idx_d));
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                PUBLICAR: begin
                    estado_q  <= IDLE;
                    ocupado_q <= 1'b0;
                end
                default: begin
                    estado_q  <= IDLE;
                    ctl_q     <= CTL_REPOSO;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cs_n   = ctl_q.cs_n;
    assign bus.rd_n   = ctl_q.rd_n;
    assign bus.wr_n   = ctl_q.wr_n;
    assign bus.a_d    = ctl_q.a_d;
    assign bus.ad_oe  = ctl_q.ad_oe;
    assign bus.ad_out = ctl_q.ad_out;

    assign seg_x      = pub_q[0];
    assign min_x      = pub_q[1];
    assign hora_x     = pub_q[2];
    assign dia_x      = pub_q[3];
    assign mes_x      = pub_q[4];
    assign year_x     = pub_q[5];
    assign seg_crono  = pub_q[6];
    assign min_crono  = pub_q[7];
    assign hora_crono = pub_q[8];

    assign ocupado       = ocupado_q;
    assign datos_validos = dv_q;

endmodule

// File: tb/tb_rtc_lector_bus.sv
// tb_rtc_lector_bus: directed bench for rtc_lector_bus with a small RTC model,
// an expected-data scoreboard and an address/strobe bus monitor.
module tb_rtc_lector_bus;

    localparam int TP  = 4;
    localparam int TE  = 2;
    localparam int PER = 500;
`ifdef RTC_TRANSFERENCIA_EN
    localparam int LAT = 1 + 9 * (2 * TP + 2 * TE) + TP + TE;
    localparam bit CMD = 1'b1;
`else
    localparam int LAT = 1 + 9 * (2 * TP + 2 * TE);
    localparam bit CMD = 1'b0;
`endif
    localparam logic [7:0] DIRS [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                        8'h41, 8'h42, 8'h43};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic leer_ya = 1'b0;
    logic pausa = 1'b0;
    logic [7:0] o_seg, o_min, o_hora, o_dia, o_mes, o_year, o_sc, o_mc, o_hc;
    logic ocupado, dv;

    rtc_lector_bus_if bus ();

    rtc_lector_bus #(.T_PULSO(TP), .T_ESPERA(TE), .PERIODO(PER)) dut (
        .reloj_nexys   (clk),
        .reset_total   (rst_n),
        .leer_ya       (leer_ya),
        .pausa         (pausa),
        .bus           (bus),
        .seg_x         (o_seg),
        .min_x         (o_min),
        .hora_x        (o_hora),
        .dia_x         (o_dia),
        .mes_x         (o_mes),
        .year_x        (o_year),
        .seg_crono     (o_sc),
        .min_crono     (o_mc),
        .hora_crono    (o_hc),
        .ocupado       (ocupado),
        .datos_validos (dv)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RTC model: latches the address strobe, returns the addressed byte.
    logic [7:0] mem [0:255];
    logic [7:0] lat_addr = 8'h00;
    always @(posedge clk)
        if (!bus.cs_n && !bus.wr_n && !bus.a_d) lat_addr <= bus.ad_out;
    assign bus.ad_in = mem[lat_addr];

    wire [71:0] obs_pub = {o_seg, o_min, o_hora, o_dia, o_mes, o_year, o_sc, o_mc, o_hc};

    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_cnt = 0;
    logic [71:0] exp_q[$];
    logic [7:0]  exp_addr[$];

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h (failure #%0d)", tag, obs, expv, fail_cnt);
        end
    endtask

    task automatic set_data(input logic [7:0] s, m, h, d, mo, y, cs, cm, ch);
        mem[8'h21] = s;  mem[8'h22] = m;  mem[8'h23] = h;
        mem[8'h24] = d;  mem[8'h25] = mo; mem[8'h26] = y;
        mem[8'h41] = cs; mem[8'h42] = cm; mem[8'h43] = ch;
    endtask

    function automatic logic [71:0] make_exp();
        logic [71:0] e;
        e = '0;
        for (int i = 0; i < 9; i++) e = {e[63:0], mem[DIRS[i]]};
        return e;
    endfunction

    task automatic push_addrs();
        if (CMD) exp_addr.push_back(8'hF0);
        for (int i = 0; i < 9; i++) exp_addr.push_back(DIRS[i]);
    endtask

    task automatic wait_dv(input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (dv) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        exp_addr.delete();
        rst_n = 1'b1;
    endtask

    task automatic pulse_leer(output int k);
        @(negedge clk);
        leer_ya = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        leer_ya = 1'b0;
    endtask

    // Bus monitor: strobe lengths, gaps, address order, bus safety, data scoreboard.
    int wr_len = 0, rd_len = 0, gap = 0, cs_fall_cnt = 0, dv_cnt = 0;
    logic prev_cs = 1'b1, prev_ocup = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            wr_len = 0; rd_len = 0; gap = 0; prev_cs = 1'b1; prev_ocup = 1'b0;
        end else begin
            if (!bus.wr_n) begin
                if (wr_len == 0) begin
                    chk("addr_phase", {bus.ad_oe, bus.a_d, bus.cs_n}, 3'b100);
                    if (exp_addr.size() == 0) chk("addr_extra", exp_addr.size(), 1);
                    else chk("addr_order", bus.ad_out, exp_addr.pop_front());
                end
                wr_len++;
            end else if (wr_len != 0) begin
                chk("wr_len", wr_len, TP);
                wr_len = 0;
            end
            if (!bus.rd_n) begin
                if (rd_len == 0) chk("read_phase", {bus.a_d, bus.cs_n}, 2'b10);
                chk("oe_while_rd", bus.ad_oe, 1'b0);
                chk("rd_wr_overlap", bus.wr_n, 1'b1);
                rd_len++;
            end else if (rd_len != 0) begin
                chk("rd_len", rd_len, TP);
                rd_len = 0;
            end
            if (bus.cs_n) gap++;
            else begin
                if (prev_cs) begin
                    cs_fall_cnt++;
                    if (prev_ocup) chk("gap_len", gap, TE);
                end
                gap = 0;
            end
            prev_cs = bus.cs_n;
            prev_ocup = ocupado;
            if (dv) begin
                dv_cnt++;
                if (exp_q.size() == 0) chk("dv_unexpected", exp_q.size(), 1);
                else chk("pub_data", obs_pub, exp_q.pop_front());
            end
        end
    end

    int r0, k, k2, j, at, at2, d0, c0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset state, then automatic sweep after PER cycles.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d, bus.ad_oe}, 5'b11110);
        chk("rst_adout", bus.ad_out, 8'h00);
        chk("rst_pub", obs_pub, 72'h0);
        chk("rst_flags", {ocupado, dv}, 2'b00);
        set_data(8'h59, 8'h30, 8'h12, 8'h31, 8'h12, 8'h24, 8'h11, 8'h22, 8'h33);
        exp_q.push_back(make_exp());
        push_addrs();
        r0 = cyc;
        rst_n = 1'b1;
        repeat (250) @(negedge clk);
        chk("idle_ctl", {bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_oe, ocupado}, 5'b11100);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!bus.cs_n) begin
                at = cyc;
                break;
            end
        end
        chk("auto_start", at, r0 + PER + 1);
        wait_dv(LAT + 10, at);
        chk("auto_dv_time", at, r0 + PER + LAT);

        // leer_ya sweep with the reference data; outputs stay put until the pulse.
        do_reset();
        set_data(8'h07, 8'h07, 8'h07, 8'h05, 8'h05, 8'h05, 8'h01, 8'h02, 8'h03);
        exp_q.push_back(make_exp());
        push_addrs();
        pulse_leer(k);
        while (cyc < k + LAT - 1) @(negedge clk);
        chk("pre_dv_flag", dv, 1'b0);
        chk("pre_dv_data", obs_pub, 72'h0);
        @(negedge clk);
        chk("dv_time", dv, 1'b1);
        @(negedge clk);
        chk("dv_one_cycle", {dv, ocupado}, 2'b00);

        // pausa holds the request; release starts next cycle; pausa mid-sweep ignored.
        do_reset();
        pausa = 1'b1;
        exp_q.push_back(make_exp());
        push_addrs();
        c0 = cs_fall_cnt;
        pulse_leer(k);
        repeat (20) @(negedge clk);
        chk("pausa_no_bus", cs_fall_cnt, c0);
        chk("pausa_idle", ocupado, 1'b0);
        pausa = 1'b0;
        j = cyc + 1;
        @(negedge clk);
        chk("pausa_release", {bus.cs_n, ocupado}, 2'b01);
        repeat (30) @(negedge clk);
        pausa = 1'b1;
        wait_dv(LAT + 10, at);
        chk("pausa_dv_time", at, j - 1 + LAT);
        pausa = 1'b0;

        // Three requests during a sweep collapse into one more sweep.
        do_reset();
        set_data(8'h23, 8'h45, 8'h18, 8'h09, 8'h11, 8'h25, 8'h58, 8'h59, 8'h01);
        exp_q.push_back(make_exp());
        push_addrs();
        d0 = dv_cnt;
        pulse_leer(k);
        repeat (20) @(negedge clk);
        exp_q.push_back(make_exp());
        push_addrs();
        for (int n = 0; n < 3; n++) begin
            leer_ya = 1'b1;
            @(negedge clk);
            leer_ya = 1'b0;
            repeat (10) @(negedge clk);
        end
        wait_dv(LAT + 10, at);
        chk("multi_dv1", at, k + LAT);
        wait_dv(LAT + 10, at2);
        chk("multi_dv2", at2, at + 1 + LAT);
        repeat (60) @(negedge clk);
        chk("multi_count", dv_cnt - d0, 2);

        // Reset at cycle 50 of a sweep aborts it and clears published data.
        do_reset();
        set_data(8'h45, 8'h15, 8'h09, 8'h01, 8'h06, 8'h99, 8'h07, 8'h08, 8'h09);
        exp_q.push_back(make_exp());
        push_addrs();
        pulse_leer(k);
        wait_dv(LAT + 10, at);
        chk("pre_abort_dv", at, k + LAT);
        set_data(8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11);
        push_addrs();
        pulse_leer(k2);
        while (cyc < k2 + 49) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ctl", {bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d, bus.ad_oe}, 5'b11110);
        chk("abort_pub", obs_pub, 72'h0);
        chk("abort_flags", {ocupado, dv}, 2'b00);
        @(negedge clk);
        exp_addr.delete();
        rst_n = 1'b1;
        d0 = dv_cnt;
        repeat (150) @(negedge clk);
        chk("abort_no_dv", dv_cnt - d0, 0);
        chk("abort_pub_hold", obs_pub, 72'h0);
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
